// File: rtl/term_write_ctrl.sv
// rtl/term_write_ctrl.sv - Apple-1 style terminal write sequencer: cursor, wrap, scroll and clear-screen
module term_write_ctrl #(
    parameter int COLS   = 40,
    parameter int ROWS   = 24,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              da,
    input  logic [6:0]        char_in,
    output logic              rda,
    input  logic              write_window,
    input  logic              clr_req,
    input  logic              scroll_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_char,
    output logic              scroll,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SLOT = 2'd1,
        S_SCROLL    = 2'd2,
        S_CLEAR     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

    state_t            state_q, state_d;
    logic              da_q;
    logic [6:0]        char_q, char_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [5:0]        wr_char_q, wr_char_d;
    logic              scroll_q, scroll_d;
    logic              rda_q, rda_d;

    logic              accept;
    logic              printable;
    logic              newline;
    logic [ADDR_W-1:0] cur_addr;

    assign accept    = da & ~da_q;
    assign printable = (char_q >= 7'h20) && (char_q <= 7'h5F);
    assign newline   = (char_q == 7'h0D) || (printable && (col_q == LAST_COL));
    assign cur_addr  = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            da_q      <= 1'b0;
            char_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_char_q <= '0;
            scroll_q  <= 1'b0;
            rda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            da_q      <= da;
            char_q    <= char_d;
            col_q     <= col_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_char_q <= wr_char_d;
            scroll_q  <= scroll_d;
            rda_q     <= rda_d;
        end
    end

    // A scroll out of the last row is deferred a cycle (pend) so it never overlaps the write strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req)     state_d = S_CLEAR;
                else if (accept) state_d = S_WAIT_SLOT;
            end
            S_WAIT_SLOT: begin
                if (clr_req) state_d = S_CLEAR;
                else if (write_window) begin
                    if (newline && (row_q == LAST_ROW)) state_d = S_SCROLL;
                    else                                state_d = S_IDLE;
                end
            end
            S_SCROLL: begin
                if (clr_req)                     state_d = S_CLEAR;
                else if (!pend_q && scroll_done) state_d = S_IDLE;
            end
            S_CLEAR: begin
                if (write_window && (cnt_q == LAST_ADDR)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        char_d    = char_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_char_d = wr_char_q;
        scroll_d  = 1'b0;
        rda_d     = (state_d == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (clr_req)     cnt_d  = '0;
                else if (accept) char_d = char_in;
            end
            S_WAIT_SLOT: begin
                if (clr_req) cnt_d = '0;
                else if (write_window) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_char_d = char_q[5:0];
                        col_d     = col_q + 6'd1;
                    end
                    if (newline) begin
                        col_d = '0;
                        if (row_q != LAST_ROW) row_d  = row_q + 5'd1;
                        else                   pend_d = 1'b1;
                    end
                end
            end
            S_SCROLL: begin
                if (clr_req) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    scroll_d = 1'b1;
                    pend_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                if (write_window) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_char_d = 6'h20;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d = '0;
                        col_d = '0;
                        row_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rda        = rda_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_char    = wr_char_q;
    assign scroll     = scroll_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_term_write_ctrl.sv
// tb/tb_term_write_ctrl.sv - self-checking bench for term_write_ctrl against a cursor/screen model
module tb_term_write_ctrl;

    localparam int COLS = 40;
    localparam int ROWS = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       da = 1'b0;
    logic [6:0] char_in = '0;
    logic       rda;
    logic       write_window = 1'b0;
    logic       clr_req = 1'b0;
    logic       scroll_done = 1'b0;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [5:0] wr_char;
    logic       scroll;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;

    int n_vec = 0;
    int n_err = 0;
    int mcol = 0;
    int mrow = 0;

    term_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .da(da), .char_in(char_in), .rda(rda),
        .write_window(write_window), .clr_req(clr_req), .scroll_done(scroll_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .scroll(scroll),
        .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_rda", rda, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_scroll", scroll, 0);
        chk("rst_wr_char", wr_char, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_row", cursor_row, 0);
    endtask

    // Offer one character and follow it to completion, predicting everything from the model cursor.
    task automatic send_char(input logic [6:0] c);
        bit pr, nl, scr;
        da = 1'b0;
        tick();
        da = 1'b1;
        char_in = c;
        tick();
        chk("rda_drop", rda, 0);
        da = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("wait_no_wr", wr_en, 0);
        end
        write_window = 1'b1;
        tick();
        write_window = 1'b0;
        pr  = (c >= 7'h20) && (c <= 7'h5F);
        nl  = 1'b0;
        scr = 1'b0;
        chk("wr_en", wr_en, int'(pr));
        if (pr) begin
            chk("wr_addr", wr_addr, mrow * COLS + mcol);
            chk("wr_char", wr_char, int'(c) % 64);
            mcol++;
            if (mcol == COLS) nl = 1'b1;
        end else if (c == 7'h0D) begin
            nl = 1'b1;
        end
        if (nl) begin
            mcol = 0;
            if (mrow < ROWS - 1) mrow++;
            else scr = 1'b1;
        end
        chk("cursor_col", cursor_col, mcol);
        chk("cursor_row", cursor_row, mrow);
        if (scr) begin
            chk("scroll_rda", rda, 0);
            tick();
            chk("scroll_pulse", scroll, 1);
            chk("scroll_no_wr", wr_en, 0);
            tick();
            chk("scroll_one", scroll, 0);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("scroll_hold", rda, 0);
            end
            scroll_done = 1'b1;
            tick();
            scroll_done = 1'b0;
        end
        chk("rda_back", rda, 1);
    endtask

    function automatic logic [6:0] rand_char();
        int r, v;
        r = $urandom_range(0, 9);
        if (r == 0) return 7'h0D;
        if (r == 1) begin
            v = $urandom_range(0, 62);
            if (v >= 32) v = v + 64;
            if (v == 13) v = 7;
            return 7'(v);
        end
        return 7'($urandom_range(32, 95));
    endfunction

    initial begin
        tick();
        tick();
        chk_reset_vals();
        reset = 1'b0;
        tick();

        send_char(7'h41);

        // Held da after a write must not retrigger.
        repeat (2) begin
            write_window = 1'b1;
            tick();
            write_window = 1'b0;
            chk("hold_no_wr", wr_en, 0);
            chk("hold_col", cursor_col, mcol);
            tick();
        end
        send_char(7'h42);

        for (int i = 0; i < 80; i++) send_char(rand_char());

        // Clear request colliding with the write slot wins.
        da = 1'b0;
        tick();
        da = 1'b1;
        char_in = 7'h41;
        tick();
        chk("clr_rda_drop", rda, 0);
        clr_req = 1'b1;
        write_window = 1'b1;
        tick();
        clr_req = 1'b0;
        write_window = 1'b0;
        chk("clr_no_char_wr", wr_en, 0);
        chk("clr_col_kept", cursor_col, mcol);
        chk("clr_row_kept", cursor_row, mrow);
        chk("clr_rda", rda, 0);
        for (int i = 0; i < COLS * ROWS; i++) begin
            repeat ($urandom_range(0, 1)) begin
                tick();
                chk("clr_gap", wr_en, 0);
            end
            write_window = 1'b1;
            tick();
            write_window = 1'b0;
            chk("clr_wr_en", wr_en, 1);
            chk("clr_addr", wr_addr, i);
            chk("clr_char", wr_char, 32);
        end
        mcol = 0;
        mrow = 0;
        chk("clr_home_col", cursor_col, 0);
        chk("clr_home_row", cursor_row, 0);
        chk("clr_done_rda", rda, 1);

        // Wrap at (39,5) then CR from (7,6).
        repeat (5) send_char(7'h0D);
        repeat (COLS - 1) send_char(7'($urandom_range(32, 95)));
        send_char(7'h58);
        repeat (7) send_char(7'($urandom_range(32, 95)));
        send_char(7'h0D);

        // Bottom-right write forces a scroll, then CR on the last row scrolls again.
        repeat (16) send_char(7'h0D);
        repeat (COLS - 1) send_char(7'($urandom_range(32, 95)));
        send_char(7'h20);
        send_char(7'h0D);

        // Reset in the middle of a clear.
        da = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr2_rda", rda, 0);
        for (int i = 0; i <= 300; i++) begin
            write_window = 1'b1;
            tick();
            write_window = 1'b0;
            chk("clr2_addr", wr_addr, i);
        end
        reset = 1'b1;
        #1;
        chk_reset_vals();
        mcol = 0;
        mrow = 0;
        tick();
        reset = 1'b0;
        tick();
        send_char(7'h07);
        send_char(7'h41);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/term_write_ctrl.md
Name: term_write_ctrl

Overview:
Sequences character writes from the PIA display port into the terminal's video character store, modelling Apple-1 terminal output. It handshakes with the PIA through DA/RDA, waits for the video timing's write slot, then writes or performs CR, auto-wrap, scroll and clear-screen. It owns the cursor position and the store write address. It sits between the PIA model and the character store / video timing chain.

Parameters:
COLS, 40, characters per row
ROWS, 24, rows per screen
ADDR_W, 10, width of wr_addr; must satisfy 2**ADDR_W >= COLS*ROWS

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
da  input  1  data available from PIA; a new character is offered on its rising edge
char_in  input  7  ASCII character from PIA, bit 7 already stripped
rda  output  1  ready for data to PIA; high only in IDLE
write_window  input  1  one-cycle pulse from video timing marking a legal store write slot
clr_req  input  1  clear-screen request, level, active-high
scroll_done  input  1  store finished shifting up one row
wr_en  output  1  store write strobe, one cycle
wr_addr  output  ADDR_W  store address = cursor_row*COLS + cursor_col (CLEAR: clear counter)
wr_char  output  6  6-bit display code written
scroll  output  1  one-cycle request to shift store up one row
cursor_col  output  6  current column, 0..COLS-1
cursor_row  output  5  current row, 0..ROWS-1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset (async, immediate): state IDLE, rda=1, wr_en=0, scroll=0, wr_char=0, wr_addr=0, cursor_col=0, cursor_row=0, da_q=0, clear counter=0.
- da_q registers da every cycle; accept event = da & ~da_q. A held-high da yields exactly one accept.
- States: IDLE, WAIT_SLOT, SCROLL, CLEAR.
- IDLE: rda=1. On clr_req -> CLEAR, counter=0. Otherwise on accept: latch char_in, rda=0 next cycle, -> WAIT_SLOT.
- WAIT_SLOT: rda=0. Waits for write_window. Action in the cycle write_window=1:
  - Printable (0x20..0x5F): wr_en=1 for that one cycle, wr_char=char[5:0], wr_addr=current position. Column then advances. If col was COLS-1, perform newline.
  - CR (0x0D): newline, no write.
  - Any other code: no write, no cursor change, -> IDLE.
- Newline: col=0. If row<ROWS-1, row+1 and -> IDLE. Otherwise row stays ROWS-1, scroll=1 for one cycle, -> SCROLL.
- SCROLL: rda=0. Holds until scroll_done=1, then -> IDLE next cycle. scroll_done outside SCROLL is ignored.
- CLEAR: rda=0. On each write_window: wr_en=1, wr_char=0x20, wr_addr=counter, counter+1. After write at COLS*ROWS-1: cursor home (0,0), -> IDLE.
- Write cost: one write_window per character; clearing 40x24 takes 960 windows.
- clr_req has priority in every state except CLEAR. It aborts pending char/scroll wait and drops the latched char.
- clr_req in the same cycle as a write_window in WAIT_SLOT: clear wins, no char write, no cursor change.
- clr_req held through and after CLEAR completion: re-enters CLEAR from IDLE.
- da edge during non-IDLE states: ignored (da_q still tracks), not queued.
- wr_en and scroll are never high simultaneously. All outputs are registered.
- Reset mid-write or mid-CLEAR: immediate return to reset values; no partial-write completion.

Test Plan:
- Reset, da rises with char_in=0x41, write_window pulses 3 cycles later -> rda drops 1 cycle after edge; wr_en=1, wr_addr=0, wr_char=0x01 on window cycle; cursor_col=1; rda=1 again.
- da held high across 2 windows after one write -> exactly one wr_en; a second da rising edge yields a second write at wr_addr=1.
- Cursor at (39,5), write 0x58 -> wr_addr=239, then cursor (0,6); then CR from (7,6) -> cursor (0,7), no wr_en.
- Cursor at (39,23), write 0x20 -> wr_addr=959, scroll=1 one cycle, rda=0 until scroll_done; cursor (0,23), rda=1 after.
- clr_req during WAIT_SLOT coinciding with write_window -> no char write; 960 wr_en pulses with addresses 0..959 and wr_char=0x20; cursor (0,0); rda=1 after last.
- Assert reset mid-CLEAR at counter=300, and separately send char 0x07 -> all outputs return to reset values at once; BEL consumes one window with no wr_en and no cursor change.
